dual_hash_scheduler: RTL and testbench

Sequences the dual SHA-256 hasher pair for one unit of work. It latches new work from the comm block and issues nonces to the first-stage hasher. It also tracks pipeline latency, so only results that belong to the current work are checked against the golden target. Golden nonces are buffered in a small FIFO with a valid/ready handshake toward the comm block. It replaces the free-running nonce/reset logic in the top level and eliminates the invalid-result window after new work.

---
 rtl/dual_hash_scheduler.sv | 122 ++++++++++++
 tb/tb_dual_hash_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_hash_scheduler.sv
// Sequences nonce issue for the dual hasher pair and checks only results of the current work.
// Work latch 1 cycle; golden nonces queue in a FWFT FIFO, overflowing pushes are dropped (sticky flag).
module dual_hash_scheduler #(
    parameter int          LATENCY       = 254,
    parameter int          NONCE_WIDTH   = 31,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] GOLDEN_TARGET = 32'hA41F32E7
) (
    input  logic                   hash_clk,
    input  logic                   reset_n,
    input  logic                   rx_new_work,
    input  logic [255:0]           rx_midstate,
    input  logic [95:0]            rx_data,
    output logic [255:0]           tx_midstate,
    output logic [95:0]            tx_data,
    output logic [NONCE_WIDTH-1:0] tx_nonce,
    input  logic [31:0]            rx_hash2_w0,
    input  logic [31:0]            rx_hash2_w1,
    output logic                   tx_golden_valid,
    output logic [31:0]            tx_golden_nonce,
    input  logic                   rx_golden_ready,
    output logic                   tx_idle,
    output logic                   tx_overflow
);

    localparam int FW = $clog2(LATENCY);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [NONCE_WIDTH-1:0] NONCE_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [FW-1:0]          fill_cnt;
    logic [NONCE_WIDTH-1:0] res_nonce;
    logic [31:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr, wr_idx1;
    logic [CW-1:0]          count, free;
    logic                   busy, cmp_en, hit0, hit1, pop, acc0, acc1, drop;
    logic [31:0]            ent0, ent1;

    always_ff @(posedge hash_clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_FILL:  if (fill_cnt == FW'(LATENCY - 1)) state_nxt = S_RUN;
            S_RUN: begin
                if (res_nonce == NONCE_MAX)     state_nxt = S_IDLE;
                else if (tx_nonce == NONCE_MAX) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (res_nonce == NONCE_MAX) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (rx_new_work) state_nxt = S_FILL;
    end

    always_comb begin
        tx_idle = (state == S_IDLE);
        busy    = (state != S_IDLE);
        cmp_en  = (state == S_RUN) || (state == S_DRAIN);
    end

    // A same-cycle pop frees a slot; with one slot left for two hits, core 0 wins.
    always_comb begin
        pop     = tx_golden_valid && rx_golden_ready;
        hit0    = cmp_en && !rx_new_work && (rx_hash2_w0 == GOLDEN_TARGET);
        hit1    = cmp_en && !rx_new_work && (rx_hash2_w1 == GOLDEN_TARGET);
        free    = CW'(FIFO_DEPTH) - count + CW'(pop);
        acc0    = hit0 && (free != '0);
        acc1    = hit1 && (acc0 ? (free >= CW'(2)) : (free != '0));
        drop    = (hit0 && !acc0) || (hit1 && !acc1);
        wr_idx1 = acc0 ? wr_ptr + AW'(1) : wr_ptr;
        ent0    = {1'b0, 31'(res_nonce)};
        ent1    = {1'b1, 31'(res_nonce)};
    end

    assign tx_golden_valid = (count != '0);
    assign tx_golden_nonce = tx_golden_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge hash_clk) begin
        if (acc0) mem[wr_ptr]  <= ent0;
        if (acc1) mem[wr_idx1] <= ent1;
    end

    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            tx_midstate <= '0;
            tx_data     <= '0;
            tx_nonce    <= '0;
            fill_cnt    <= '0;
            res_nonce   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else if (rx_new_work) begin
            tx_midstate <= rx_midstate;
            tx_data     <= rx_data;
            tx_nonce    <= '0;
            fill_cnt    <= '0;
            res_nonce   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (busy && tx_nonce != NONCE_MAX) tx_nonce <= tx_nonce + 1'b1;
            if (state == S_FILL) fill_cnt <= fill_cnt + 1'b1;
            if (cmp_en) res_nonce <= res_nonce + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= wr_ptr + AW'(acc0) + AW'(acc1);
            count  <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
            if (drop) tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_hash_scheduler.sv
// Bench for dual_hash_scheduler with a small LATENCY/NONCE_WIDTH so whole sweeps are short.
module tb_dual_hash_scheduler;

    localparam int          L     = 8;
    localparam int          NW    = 4;
    localparam int          D     = 4;
    localparam logic [31:0] T     = 32'hA41F32E7;
    localparam int          MAXN  = (1 << NW) - 1;
    localparam int          SWEEP = L + (1 << NW);

    logic          hash_clk;
    logic          reset_n;
    logic          rx_new_work;
    logic [255:0]  rx_midstate;
    logic [95:0]   rx_data;
    logic [255:0]  tx_midstate;
    logic [95:0]   tx_data;
    logic [NW-1:0] tx_nonce;
    logic [31:0]   rx_hash2_w0, rx_hash2_w1;
    logic          tx_golden_valid;
    logic [31:0]   tx_golden_nonce;
    logic          rx_golden_ready;
    logic          tx_idle;
    logic          tx_overflow;

    dual_hash_scheduler #(
        .LATENCY(L), .NONCE_WIDTH(NW), .FIFO_DEPTH(D), .GOLDEN_TARGET(T)
    ) dut (
        .hash_clk(hash_clk), .reset_n(reset_n), .rx_new_work(rx_new_work),
        .rx_midstate(rx_midstate), .rx_data(rx_data),
        .tx_midstate(tx_midstate), .tx_data(tx_data), .tx_nonce(tx_nonce),
        .rx_hash2_w0(rx_hash2_w0), .rx_hash2_w1(rx_hash2_w1),
        .tx_golden_valid(tx_golden_valid), .tx_golden_nonce(tx_golden_nonce),
        .rx_golden_ready(rx_golden_ready), .tx_idle(tx_idle), .tx_overflow(tx_overflow)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    // Reference: m_k is the cycle index since the work latch (0 = first cycle showing nonce 0).
    bit           m_active;
    int           m_k;
    logic [31:0]  m_q[$];
    bit           m_ovf;
    logic [255:0] m_mid;
    logic [95:0]  m_dat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          k;
        bit          m0;
        bit          m1;
        bit          exp_vld;
        logic [31:0] exp_head;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_active = 0; m_k = 0; m_q.delete(); m_ovf = 0; m_mid = '0; m_dat = '0;
            return;
        end
        if (rx_new_work) begin
            m_active = 1; m_k = 0; m_q.delete(); m_ovf = 0;
            m_mid = rx_midstate; m_dat = rx_data;
            return;
        end
        if (m_q.size() > 0 && rx_golden_ready) void'(m_q.pop_front());
        if (m_active && m_k >= L && m_k < SWEEP) begin
            if (rx_hash2_w0 == T) begin
                if (m_q.size() < D) m_q.push_back(32'(m_k - L));
                else m_ovf = 1;
            end
            if (rx_hash2_w1 == T) begin
                if (m_q.size() < D) m_q.push_back(32'h8000_0000 | 32'(m_k - L));
                else m_ovf = 1;
            end
        end
        if (m_active) m_k++;
    endtask

    task automatic compare_all();
        int en;
        en = m_active ? ((m_k < MAXN) ? m_k : MAXN) : 0;
        check("tx_nonce", 256'(tx_nonce), 256'(en));
        check("tx_idle", 256'(tx_idle), 256'(!m_active || m_k >= SWEEP));
        check("tx_golden_valid", 256'(tx_golden_valid), 256'(m_q.size() != 0));
        check("tx_golden_nonce", 256'(tx_golden_nonce), 256'((m_q.size() != 0) ? m_q[0] : 32'h0));
        check("tx_overflow", 256'(tx_overflow), 256'(m_ovf));
        check("tx_midstate", tx_midstate, m_mid);
        check("tx_data", 256'(tx_data), 256'(m_dat));
    endtask

    task automatic tick();
        model_step();
        @(posedge hash_clk);
        #1;
        compare_all();
    endtask

    task automatic set_hash(input bit a, input bit b);
        rx_hash2_w0 = a ? T : 32'h0;
        rx_hash2_w1 = b ? T : 32'h0;
    endtask

    task automatic rand_work();
        for (int i = 0; i < 8; i++) rx_midstate[i*32 +: 32] = $urandom;
        for (int i = 0; i < 3; i++) rx_data[i*32 +: 32] = $urandom;
    endtask

    task automatic start_work();
        rand_work();
        rx_new_work = 1'b1;
        tick();
        rx_new_work = 1'b0;
    endtask

    task automatic drive_to(input int k);
        int guard;
        guard = 0;
        while (m_k < k && guard < 200) begin
            tick();
            guard++;
        end
        check("drive_to_bound", 256'(m_k), 256'(k));
    endtask

    vec_t tbl[7];
    logic [31:0] exp_list[4];
    int n;

    initial begin
        tbl[0] = '{13, 1'b0, 1'b1, 1'b1, 32'h8000_0005};
        tbl[1] = '{3,  1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2] = '{7,  1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{8,  1'b1, 1'b0, 1'b1, 32'h0000_0000};
        tbl[4] = '{10, 1'b1, 1'b1, 1'b1, 32'h0000_0002};
        tbl[5] = '{23, 1'b1, 1'b0, 1'b1, 32'h0000_000F};
        tbl[6] = '{24, 1'b1, 1'b1, 1'b0, 32'h0};

        reset_n = 1'b0; rx_new_work = 1'b0; rx_midstate = '0; rx_data = '0;
        rx_golden_ready = 1'b0; set_hash(0, 0);
        m_active = 0; m_k = 0; m_ovf = 0; m_mid = '0; m_dat = '0;
        tick();
        tick();
        check("rst_idle", 256'(tx_idle), 256'(1));
        check("rst_nonce", 256'(tx_nonce), 256'(0));
        check("rst_valid", 256'(tx_golden_valid), 256'(0));
        check("rst_head", 256'(tx_golden_nonce), 256'(0));
        check("rst_ovf", 256'(tx_overflow), 256'(0));
        check("rst_mid", tx_midstate, 256'(0));
        reset_n = 1'b1;

        // Nominal sweep: idle 1+L+2^NW cycles after the pulse.
        start_work();
        n = 1;
        check("sweep_busy", 256'(tx_idle), 256'(0));
        while (!tx_idle && n < 100) begin
            tick();
            n++;
        end
        check("sweep_len", 256'(n), 256'(25));
        check("sweep_nonce", 256'(tx_nonce), 256'(15));
        check("sweep_no_golden", 256'(tx_golden_valid), 256'(0));

        foreach (tbl[i]) begin
            start_work();
            drive_to(tbl[i].k);
            set_hash(tbl[i].m0, tbl[i].m1);
            tick();
            set_hash(0, 0);
            check("tbl_valid", 256'(tx_golden_valid), 256'(tbl[i].exp_vld));
            check("tbl_head", 256'(tx_golden_nonce), 256'(tbl[i].exp_head));
            if (tbl[i].exp_vld && !(tbl[i].m0 && tbl[i].m1)) begin
                rx_golden_ready = 1'b1;
                tick();
                rx_golden_ready = 1'b0;
                check("tbl_popped", 256'(tx_golden_valid), 256'(0));
            end
        end

        // Match coinciding with new work: flushed, nothing pushed.
        start_work();
        drive_to(10);
        set_hash(1, 0);
        tick();
        set_hash(1, 1);
        drive_to(12);
        check("pre_flush_valid", 256'(tx_golden_valid), 256'(1));
        rand_work();
        rx_new_work = 1'b1;
        tick();
        rx_new_work = 1'b0;
        set_hash(0, 0);
        check("flush_valid", 256'(tx_golden_valid), 256'(0));
        check("flush_nonce", 256'(tx_nonce), 256'(0));
        check("flush_mid", tx_midstate, rx_midstate);

        // Dual match on nonces 2,3,4 with no consumer: third pair overflows.
        start_work();
        drive_to(10);
        set_hash(1, 1);
        for (int i = 0; i < 3; i++) tick();
        set_hash(0, 0);
        check("ovf_set", 256'(tx_overflow), 256'(1));
        tick();
        check("ovf_sticky", 256'(tx_overflow), 256'(1));
        exp_list = '{32'h0000_0002, 32'h8000_0002, 32'h0000_0003, 32'h8000_0003};
        rx_golden_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_content", 256'(tx_golden_nonce), 256'(exp_list[i]));
            tick();
        end
        rx_golden_ready = 1'b0;
        check("ovf_drained", 256'(tx_golden_valid), 256'(0));

        // Full FIFO with same-cycle pop accepts the push.
        start_work();
        drive_to(10);
        set_hash(1, 1);
        tick();
        tick();
        set_hash(0, 1);
        rx_golden_ready = 1'b1;
        tick();
        set_hash(0, 0);
        check("fullpop_ovf", 256'(tx_overflow), 256'(0));
        exp_list = '{32'h8000_0002, 32'h0000_0003, 32'h8000_0003, 32'h8000_0004};
        for (int i = 0; i < 4; i++) begin
            check("fullpop_content", 256'(tx_golden_nonce), 256'(exp_list[i]));
            tick();
        end
        rx_golden_ready = 1'b0;
        check("fullpop_count", 256'(tx_golden_valid), 256'(0));

        // Reset during RUN with a pending entry.
        start_work();
        drive_to(10);
        set_hash(1, 0);
        tick();
        set_hash(0, 0);
        drive_to(14);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_idle", 256'(tx_idle), 256'(1));
        check("midrst_nonce", 256'(tx_nonce), 256'(0));
        check("midrst_valid", 256'(tx_golden_valid), 256'(0));
        check("midrst_head", 256'(tx_golden_nonce), 256'(0));
        check("midrst_ovf", 256'(tx_overflow), 256'(0));
        check("midrst_mid", tx_midstate, 256'(0));
        check("midrst_data", 256'(tx_data), 256'(0));
        start_work();
        check("restart_nonce", 256'(tx_nonce), 256'(0));
        check("restart_busy", 256'(tx_idle), 256'(0));

        // Random traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(499) != 0);
            rx_new_work = ($urandom_range(39) == 0);
            if (rx_new_work) rand_work();
            rx_hash2_w0 = ($urandom_range(4) == 0) ? T : $urandom;
            rx_hash2_w1 = ($urandom_range(4) == 0) ? T : $urandom;
            rx_golden_ready = ($urandom_range(2) == 0);
            tick();
        end
        reset_n = 1'b1; rx_new_work = 1'b0; rx_golden_ready = 1'b0; set_hash(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
